// File: rtl/cpu_axi_bridge_mo.sv
// cpu_axi_bridge_mo: bridges the CPU's SRAM-like instruction and data ports onto one AXI3 master.
// Only single-beat transfers are issued. Each port may keep up to OUTSTANDING reads in flight.
// Read responses are steered back to a port by rid. A write holds data_ok until its B response.
//
// Ports:
//   clk, resetn               clock; synchronous active-low reset
//   inst_* / data_*           SRAM-like request ports (req/wr/size/addr/wdata in,
//                             addr_ok/data_ok/rdata out); inst_wr and inst_wdata are unused
//   ar*, r*, aw*, w*, b*      AXI3 master channels (4-bit IDs, 32-bit address and data)
module cpu_axi_bridge_mo #(
    parameter int unsigned OUTSTANDING = 4,
    parameter logic [3:0]  INST_ID     = 4'd0,
    parameter logic [3:0]  DATA_ID     = 4'd1
) (
    input  logic        clk,
    input  logic        resetn,
    // instruction port
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // data port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // AR channel
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    // R channel
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    // AW channel
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    // W channel
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    // B channel
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);

    localparam logic [3:0] MaxCnt = 4'(OUTSTANDING);

    typedef enum logic [1:0] {
        WIdle,
        WAddrData,
        WResp
    } wstate_e;

    wstate_e     wstate_q, wstate_d;
    logic        arvalid_q;
    logic [3:0]  arid_q;
    logic [31:0] araddr_q;
    logic [2:0]  arsize_q;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] awaddr_q;
    logic [2:0]  awsize_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic [3:0]  icnt_q, icnt_d;
    logic [3:0]  dcnt_q, dcnt_d;

    logic ar_free, i_ret, d_ret, i_acc, dr_acc, w_acc;
    logic i_room, d_room, b_done, bready_c;

    // Inputs with no function in this bridge.
    logic unused_ok;
    assign unused_ok = ^{inst_wr, inst_wdata, rresp, rlast, bid, bresp};

    function automatic logic [3:0] calc_wstrb(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            2'd0: strb = 4'b0001 << off;
            2'd1: begin
                if (off == 2'd0) strb = 4'b0011;
                else if (off == 2'd2) strb = 4'b1100;
            end
            2'd2: if (off == 2'd0) strb = 4'b1111;
            default: strb = 4'b0000;
        endcase
        return strb;
    endfunction

    // R channel: always ready out of reset; beats with an unknown rid are dropped.
    assign rready = resetn;
    assign i_ret  = resetn && rvalid && (rid == INST_ID);
    assign d_ret  = resetn && rvalid && (rid == DATA_ID);

    // A matching R beat in this cycle frees a slot, so a full port may accept again.
    assign i_room = (icnt_q < MaxCnt) || i_ret;
    assign d_room = (dcnt_q < MaxCnt) || d_ret;

    assign ar_free = !arvalid_q || arready;

    // A write needs an idle write engine and no data reads in flight so the data port stays ordered.
    assign w_acc  = resetn && data_req && data_wr && (wstate_q == WIdle) && (dcnt_q == 4'd0);
    assign dr_acc = resetn && data_req && !data_wr && ar_free && d_room && (wstate_q == WIdle);
    // Data reads take priority over instruction reads for the shared AR slot.
    assign i_acc  = resetn && inst_req && ar_free && i_room && !dr_acc;

    assign inst_addr_ok = i_acc;
    assign data_addr_ok = w_acc || dr_acc;

    assign inst_data_ok = i_ret;
    assign inst_rdata   = i_ret ? rdata : 32'h0;
    assign data_data_ok = d_ret || b_done;
    assign data_rdata   = d_ret ? rdata : 32'h0;

    // In-flight counters; a return with nothing counted is a stale beat and is ignored.
    always_comb begin
        icnt_d = icnt_q;
        dcnt_d = dcnt_q;
        if (i_acc && !(i_ret && icnt_q != 4'd0)) begin
            icnt_d = icnt_q + 4'd1;
        end else if (!i_acc && i_ret && icnt_q != 4'd0) begin
            icnt_d = icnt_q - 4'd1;
        end
        if (dr_acc && !(d_ret && dcnt_q != 4'd0)) begin
            dcnt_d = dcnt_q + 4'd1;
        end else if (!dr_acc && d_ret && dcnt_q != 4'd0) begin
            dcnt_d = dcnt_q - 4'd1;
        end
    end

    // Write engine next state.
    always_comb begin
        wstate_d  = wstate_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_c  = 1'b0;
        b_done    = 1'b0;
        unique case (wstate_q)
            WIdle: begin
                if (w_acc) begin
                    wstate_d  = WAddrData;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                end
            end
            WAddrData: begin
                if (awready) awvalid_d = 1'b0;
                if (wready)  wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) wstate_d = WResp;
            end
            WResp: begin
                bready_c = 1'b1;
                if (bvalid) begin
                    b_done   = resetn;
                    wstate_d = WIdle;
                end
            end
            default: wstate_d = WIdle;
        endcase
    end

    assign bready = bready_c && resetn;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wstate_q  <= WIdle;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            icnt_q    <= 4'd0;
            dcnt_q    <= 4'd0;
        end else begin
            wstate_q  <= wstate_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            icnt_q    <= icnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    // Write address/data capture on acceptance.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            awaddr_q <= 32'h0;
            awsize_q <= 3'd0;
            wdata_q  <= 32'h0;
            wstrb_q  <= 4'h0;
        end else if (w_acc) begin
            awaddr_q <= data_addr;
            awsize_q <= {1'b0, data_size};
            wdata_q  <= data_wdata;
            wstrb_q  <= calc_wstrb(data_size, data_addr[1:0]);
        end
    end

    // AR slot: loaded on any read acceptance, held stable until arready.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            arvalid_q <= 1'b0;
            arid_q    <= 4'd0;
            araddr_q  <= 32'h0;
            arsize_q  <= 3'd0;
        end else if (dr_acc) begin
            arvalid_q <= 1'b1;
            arid_q    <= DATA_ID;
            araddr_q  <= data_addr;
            arsize_q  <= {1'b0, data_size};
        end else if (i_acc) begin
            arvalid_q <= 1'b1;
            arid_q    <= INST_ID;
            araddr_q  <= inst_addr;
            arsize_q  <= {1'b0, inst_size};
        end else if (arready) begin
            arvalid_q <= 1'b0;
        end
    end

    assign arid    = arid_q;
    assign araddr  = araddr_q;
    assign arlen   = 4'd0;
    assign arsize  = arsize_q;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign arvalid = arvalid_q;

    assign awid    = DATA_ID;
    assign awaddr  = awaddr_q;
    assign awlen   = 4'd0;
    assign awsize  = awsize_q;
    assign awburst = 2'b01;
    assign awlock  = 2'b00;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign awvalid = awvalid_q;

    assign wid     = DATA_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wstrb_q;
    assign wlast   = 1'b1;
    assign wvalid  = wvalid_q;

endmodule

// File: tb/tb_cpu_axi_bridge_mo.sv
// Testbench for cpu_axi_bridge_mo: directed stimulus with hand-computed expectations pushed into
// queues; monitors on the falling edge pop and compare whenever the DUT presents a response or
// completes an AR/AW/W handshake.
module tb_cpu_axi_bridge_mo;

    logic        clk, resetn;
    logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr, inst_wdata, inst_rdata;
    logic        data_req, data_wr, data_addr_ok, data_data_ok;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, wstrb, bid;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, rresp, awburst, awlock, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    cpu_axi_bridge_mo #(.OUTSTANDING(4), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
        .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .data_rdata(data_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
        .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
        .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } ar_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
    } aw_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
    } w_t;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    ar_t         exp_ar[$];
    aw_t         exp_aw[$];
    w_t          exp_w[$];

    int checks   = 0;
    int failures = 0;
    bit ignore_stale = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rbeat(input logic [3:0] id, input logic [31:0] d);
        rvalid = 1'b1;
        rid    = id;
        rdata  = d;
        if (id == 4'd0) exp_i.push_back(d);
        else if (id == 4'd1) exp_d.push_back(d);
    endtask

    task automatic ireq(input logic [31:0] a);
        inst_req  = 1'b1;
        inst_addr = a;
        inst_size = 2'd2;
    endtask

    // Response and handshake monitors.
    always @(negedge clk) begin
        logic [31:0] e;
        ar_t a;
        aw_t aw;
        w_t  w;
        if (inst_data_ok && !ignore_stale) begin
            if (exp_i.size() == 0) chk("inst_data_ok unexpected", inst_data_ok, 0);
            else begin
                e = exp_i.pop_front();
                chk("inst_rdata", inst_rdata, e);
            end
        end
        if (data_data_ok) begin
            if (exp_d.size() == 0) chk("data_data_ok unexpected", data_data_ok, 0);
            else begin
                e = exp_d.pop_front();
                chk("data_rdata", data_rdata, e);
            end
        end
        if (arvalid && arready) begin
            if (exp_ar.size() == 0) chk("ar handshake unexpected", arvalid, 0);
            else begin
                a = exp_ar.pop_front();
                chk("ar id/addr/size", {arid, araddr, arsize}, a);
            end
        end
        if (awvalid && awready) begin
            if (exp_aw.size() == 0) chk("aw handshake unexpected", awvalid, 0);
            else begin
                aw = exp_aw.pop_front();
                chk("aw addr/size", {awaddr, awsize}, aw);
            end
        end
        if (wvalid && wready) begin
            if (exp_w.size() == 0) chk("w handshake unexpected", wvalid, 0);
            else begin
                w = exp_w.pop_front();
                chk("w data/strb", {wdata, wstrb}, w);
            end
        end
    end

    initial begin
        resetn = 1'b0;
        inst_req = 0; inst_wr = 0; inst_size = 2'd2; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 2'd2; data_addr = 0; data_wdata = 0;
        arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
        awready = 0; wready = 0; bid = 4'd1; bresp = 0; bvalid = 0;

        // Reset behaviour.
        step();
        inst_req = 1'b1;
        settle();
        chk("reset inst_addr_ok", inst_addr_ok, 0);
        chk("reset rready", rready, 0);
        chk("reset bready", bready, 0);
        step();
        inst_req = 1'b0;
        resetn = 1'b1;
        settle();
        chk("post-reset arvalid", arvalid, 0);
        chk("post-reset awvalid", awvalid, 0);
        chk("post-reset rready", rready, 1);
        chk("wlast const", wlast, 1);
        chk("arburst const", arburst, 2'b01);

        // Single instruction read.
        step();
        ireq(32'hBFC0_0000);
        arready = 1'b1;
        settle();
        chk("t1 addr_ok", inst_addr_ok, 1);
        chk("t1 arvalid at T", arvalid, 0);
        exp_ar.push_back('{4'd0, 32'hBFC0_0000, 3'd2});
        step();
        inst_req = 1'b0;
        settle();
        chk("t1 arvalid at T+1", arvalid, 1);
        chk("t1 araddr", araddr, 32'hBFC0_0000);
        step();
        arready = 1'b0;
        step();
        rbeat(4'd0, 32'h3C08_0001);
        step();
        rvalid = 1'b0;

        // Back-to-back instruction reads up to the outstanding limit.
        arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            ireq(32'h0000_1000 + 32'(4 * k));
            settle();
            chk("bb accept", inst_addr_ok, 1);
            exp_ar.push_back('{4'd0, 32'h0000_1000 + 32'(4 * k), 3'd2});
        end
        step();
        ireq(32'h0000_1010);
        settle();
        chk("bb full req5", inst_addr_ok, 0);
        step();
        settle();
        chk("bb full req6 cycle", inst_addr_ok, 0);
        step();
        rbeat(4'd0, 32'h1111_0000);
        settle();
        chk("bb reopen on R", inst_addr_ok, 1);
        exp_ar.push_back('{4'd0, 32'h0000_1010, 3'd2});
        step();
        rvalid = 1'b0;
        ireq(32'h0000_1014);
        settle();
        chk("bb full again", inst_addr_ok, 0);
        step();
        inst_req = 1'b0;
        arready  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rbeat(4'd0, 32'h1111_0001 + 32'(k));
            step();
        end
        rvalid = 1'b0;

        // Simultaneous inst/data reads with AR backpressure.
        step();
        ireq(32'h0000_2000);
        data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h0000_3000; data_size = 2'd2;
        settle();
        chk("sim data_addr_ok", data_addr_ok, 1);
        chk("sim inst blocked", inst_addr_ok, 0);
        exp_ar.push_back('{4'd1, 32'h0000_3000, 3'd2});
        step();
        data_req = 1'b0;
        settle();
        chk("sim ar held blocks inst", inst_addr_ok, 0);
        chk("sim arid data", arid, 4'd1);
        step();
        settle();
        chk("sim araddr stable", araddr, 32'h0000_3000);
        chk("sim still blocked", inst_addr_ok, 0);
        step();
        arready = 1'b1;
        settle();
        chk("sim inst after arready", inst_addr_ok, 1);
        exp_ar.push_back('{4'd0, 32'h0000_2000, 3'd2});
        step();
        inst_req = 1'b0;
        step();
        arready = 1'b0;
        rbeat(4'd1, 32'hDDDD_0001);
        step();
        rbeat(4'd0, 32'hAAAA_0001);
        step();
        rvalid = 1'b0;

        // Byte write with split AW/W handshakes; a data read waits for the write.
        step();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd0;
        data_addr = 32'h8000_0003; data_wdata = 32'hAB00_0000;
        settle();
        chk("wr addr_ok", data_addr_ok, 1);
        exp_aw.push_back('{32'h8000_0003, 3'd0});
        exp_w.push_back('{32'hAB00_0000, 4'b1000});
        step();
        data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h0000_4000;
        awready = 1'b1;
        settle();
        chk("wr awvalid T+1", awvalid, 1);
        chk("wr wvalid T+1", wvalid, 1);
        chk("wr wstrb", wstrb, 4'b1000);
        chk("wr read blocked T+1", data_addr_ok, 0);
        step();
        awready = 1'b0;
        settle();
        chk("wr awvalid dropped", awvalid, 0);
        chk("wr wvalid held", wvalid, 1);
        chk("wr read blocked T+2", data_addr_ok, 0);
        step();
        wready = 1'b1;
        settle();
        chk("wr read blocked T+3", data_addr_ok, 0);
        step();
        wready = 1'b0;
        settle();
        chk("wr bready", bready, 1);
        chk("wr read blocked T+4", data_addr_ok, 0);
        step();
        bvalid = 1'b1;
        exp_d.push_back(32'h0);
        settle();
        chk("wr read blocked T+5", data_addr_ok, 0);
        step();
        bvalid  = 1'b0;
        arready = 1'b1;
        settle();
        chk("rd after write", data_addr_ok, 1);
        exp_ar.push_back('{4'd1, 32'h0000_4000, 3'd2});
        step();
        data_req = 1'b0;
        step();
        arready = 1'b0;
        rbeat(4'd1, 32'hCAFE_F00D);
        step();
        rvalid = 1'b0;

        // Reset with three reads outstanding, then stale beats.
        arready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            ireq(32'h0000_5000 + 32'(4 * k));
            settle();
            chk("rst pre accept", inst_addr_ok, 1);
            exp_ar.push_back('{4'd0, 32'h0000_5000 + 32'(4 * k), 3'd2});
        end
        step();
        inst_req = 1'b0;
        step();
        arready = 1'b0;
        resetn  = 1'b0;
        rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_5555;
        inst_req = 1'b1;
        settle();
        chk("rst mid addr_ok", inst_addr_ok, 0);
        chk("rst mid rready", rready, 0);
        step();
        step();
        resetn = 1'b1;
        rvalid = 1'b0;
        inst_req = 1'b0;
        settle();
        chk("rst after arvalid", arvalid, 0);
        chk("rst after wvalid", wvalid, 0);
        ignore_stale = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_0000 + 32'(k);
        end
        step();
        rvalid = 1'b0;
        ignore_stale = 1'b0;
        arready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            ireq(32'h0000_6000 + 32'(4 * k));
            settle();
            chk("rst cnt clean accept", inst_addr_ok, 1);
            exp_ar.push_back('{4'd0, 32'h0000_6000 + 32'(4 * k), 3'd2});
        end
        step();
        ireq(32'h0000_6010);
        settle();
        chk("rst cnt full", inst_addr_ok, 0);
        step();
        inst_req = 1'b0;
        arready  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rbeat(4'd0, 32'h6666_0000 + 32'(k));
            step();
        end
        rvalid = 1'b0;
        step();
        step();

        chk("exp_i drained", exp_i.size(), 0);
        chk("exp_d drained", exp_d.size(), 0);
        chk("exp_ar drained", exp_ar.size(), 0);
        chk("exp_aw drained", exp_aw.size(), 0);
        chk("exp_w drained", exp_w.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
